// File: rtl/ofs_plat_prim_arb_pkt_mux_pkg.sv
// Shared types and constants for the packet-granular round-robin mux.
// Also holds the modular-wrap helper used by the round-robin picker.
package ofs_plat_prim_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } t_arb_pkt_state;

   localparam int ARB_STAT_CNT_WIDTH = 16;

   // (a + b) mod n for 0 <= a,b < n, without a divider.
   function automatic int rr_wrap(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/ofs_plat_prim_arb_pkt_mux_rr_pick.sv
// Combinational round-robin search: first requester at or above i_base,
// wrapping past the top index.
module ofs_plat_prim_rr_pick
   import ofs_plat_prim_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_base,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Walk offsets from far to near so the nearest requester is assigned last.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[rr_wrap(int'(i_base), k, N)]) begin
            o_grant = '0;
            o_grant[rr_wrap(int'(i_base), k, N)] = 1'b1;
            o_idx   = IDX_W'(rr_wrap(int'(i_base), k, N));
            o_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ofs_plat_prim_arb_pkt_mux.sv
// Packet-granular round-robin mux of NUM_CLIENTS streams into one registered slot.
// Define OFS_PLAT_PRIM_ARB_PKT_MUX_STATS_EN to add per-client packet counters.
module ofs_plat_prim_arb_pkt_mux
   import ofs_plat_prim_arb_pkg::*;
#(
   parameter  int NUM_CLIENTS = 4,
   parameter  int DATA_WIDTH  = 64,
   localparam int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_CLIENTS-1:0]                in_valid,
   input  logic [NUM_CLIENTS-1:0]                in_eop,
   input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] in_data,
   output logic [NUM_CLIENTS-1:0]                in_ready,
   output logic                                  out_valid,
   output logic                                  out_eop,
   output logic [DATA_WIDTH-1:0]                 out_data,
   output logic [IDX_W-1:0]                      out_src_idx,
   input  logic                                  out_ready,
   output logic                                  busy
`ifdef OFS_PLAT_PRIM_ARB_PKT_MUX_STATS_EN
   ,
   output logic [NUM_CLIENTS-1:0][ARB_STAT_CNT_WIDTH-1:0] stat_pkt_cnt
`endif
);

   t_arb_pkt_state          r_state;
   logic [IDX_W-1:0]        r_base;
   logic [IDX_W-1:0]        r_lock_idx;
   logic                    r_out_valid;
   logic                    r_out_eop;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [IDX_W-1:0]        r_out_src;

   logic                    w_can_accept;
   logic [NUM_CLIENTS-1:0]  w_pick_grant;
   logic [IDX_W-1:0]        w_pick_idx;
   logic                    w_pick_any;
   logic [NUM_CLIENTS-1:0]  w_lock_oh;
   logic [NUM_CLIENTS-1:0]  w_ready;
   logic [IDX_W-1:0]        w_src;
   logic [IDX_W-1:0]        w_next_base;
   logic                    w_acc;
   logic                    w_eop;

   ofs_plat_prim_rr_pick #(
      .N     (NUM_CLIENTS),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req   (in_valid),
      .i_base  (r_base),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_can_accept = !r_out_valid || out_ready;
   assign w_lock_oh    = NUM_CLIENTS'(1) << r_lock_idx;

   // A single client is always offered the slot, valid or not.
   always_comb begin
      w_ready = '0;
      if (!reset && w_can_accept) begin
         if (NUM_CLIENTS == 1)          w_ready = '1;
         else if (r_state == LOCKED)    w_ready = w_lock_oh;
         else                           w_ready = w_pick_grant;
      end
   end

   assign in_ready    = w_ready;
   assign w_src       = (r_state == LOCKED) ? r_lock_idx : w_pick_idx;
   assign w_acc       = |(in_valid & w_ready);
   assign w_eop       = in_eop[w_src];
   assign w_next_base = (w_src == IDX_W'(NUM_CLIENTS - 1)) ? '0 : w_src + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ARB;
         r_base      <= '0;
         r_lock_idx  <= '0;
         r_out_valid <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
      end else if (w_can_accept) begin
         r_out_valid <= w_acc;
         if (w_acc) begin
            r_out_data <= in_data[w_src];
            r_out_eop  <= w_eop;
            r_out_src  <= w_src;
            if (w_eop) begin
               r_state <= ARB;
               r_base  <= w_next_base;
            end else if (r_state == ARB) begin
               r_state    <= LOCKED;
               r_lock_idx <= w_src;
            end
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_eop     = r_out_eop;
   assign out_data    = r_out_data;
   assign out_src_idx = r_out_src;
   assign busy        = (r_state == LOCKED);

`ifdef OFS_PLAT_PRIM_ARB_PKT_MUX_STATS_EN
   for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_stat
      logic [ARB_STAT_CNT_WIDTH-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            r_cnt <= '0;
         else if (w_acc && w_eop && (w_src == IDX_W'(g)) && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end

      assign stat_pkt_cnt[g] = r_cnt;
   end
`endif

endmodule

// File: tb/tb_ofs_plat_prim_arb_pkt_mux.sv
// Directed scenarios plus randomized traffic for ofs_plat_prim_arb_pkt_mux,
// checked against a transaction-level reference model.
module tb_ofs_plat_prim_arb_pkt_mux;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      in_valid, in_eop, in_ready;
   logic [N-1:0][DW-1:0] in_data;
   logic              out_valid, out_eop, out_ready, busy;
   logic [DW-1:0]     out_data;
   logic [IW-1:0]     out_src_idx;
`ifdef OFS_PLAT_PRIM_ARB_PKT_MUX_STATS_EN
   logic [N-1:0][15:0] stat_pkt_cnt;
`endif

   ofs_plat_prim_arb_pkt_mux #(.NUM_CLIENTS(N), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_eop      (in_eop),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_eop     (out_eop),
      .out_data    (out_data),
      .out_src_idx (out_src_idx),
      .out_ready   (out_ready),
      .busy        (busy)
`ifdef OFS_PLAT_PRIM_ARB_PKT_MUX_STATS_EN
      ,
      .stat_pkt_cnt(stat_pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: one output slot, a packet owner (-1 = none) and a rotating start point.
   bit          m_ov, m_eop;
   logic [DW-1:0] m_data;
   int          m_src, m_owner, m_base;
   int          m_cnt [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ov = 0; m_eop = 0; m_data = '0; m_src = 0; m_owner = -1; m_base = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   function automatic logic [N-1:0] m_ready();
      logic [N-1:0] r;
      r = '0;
      if (reset || !(!m_ov || out_ready)) return r;
      if (m_owner >= 0) begin
         r[m_owner] = 1'b1;
         return r;
      end
      for (int k = 0; k < N; k++) begin
         if (in_valid[(m_base + k) % N]) begin
            r[(m_base + k) % N] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic chk_out();
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_owner >= 0);
      if (m_ov) begin
         chk("out_data", out_data, m_data);
         chk("out_src_idx", out_src_idx, m_src);
         chk("out_eop", out_eop, m_eop);
      end
`ifdef OFS_PLAT_PRIM_ARB_PKT_MUX_STATS_EN
      for (int i = 0; i < N; i++) chk("stat_pkt_cnt", stat_pkt_cnt[i], m_cnt[i]);
`endif
   endtask

   // Inputs are driven at the negedge before calling; returns the accepted client or -1.
   task automatic step(output int src);
      logic [N-1:0] er;
      #1;
      er = m_ready();
      chk("in_ready", in_ready, er);
      src = -1;
      for (int i = 0; i < N; i++) if (in_valid[i] && er[i]) src = i;
      if (!m_ov || out_ready) begin
         m_ov = (src >= 0);
         if (src >= 0) begin
            m_data = in_data[src]; m_eop = in_eop[src]; m_src = src;
         end
      end
      if (src >= 0) begin
         if (in_eop[src]) begin
            m_owner = -1;
            m_base  = (src + 1) % N;
            if (m_cnt[src] < 65535) m_cnt[src]++;
         end else begin
            m_owner = src;
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk_out();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int seq [N];
      int rem [N];

      reset = 1'b1; in_valid = '1; in_eop = '0; in_data = '0; out_ready = 1'b1;
      model_reset();
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_eop", out_eop, 0);
      chk("rst_out_src", out_src_idx, 0);
      chk("rst_in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0; in_valid = '0;

      // Fairness: everyone valid with single-beat packets.
      in_valid = '1; in_eop = '1;
      for (int i = 0; i < N; i++) in_data[i] = 64'h100 + 64'(i);
      for (int j = 0; j < 6; j++) begin
         step(s);
         chk("fair_idx", out_src_idx, j % 4);
         chk("fair_valid", out_valid, 1);
      end

      // Packet lock: move base to 2, then client 2 sends 3 beats while client 0 waits.
      do_reset();
      in_valid = 4'b0010; in_eop = '1; in_data[1] = 64'h1111;
      step(s);
      in_valid = 4'b0101; in_eop = 4'b0001; in_data[0] = 64'h0A0A; in_data[2] = 64'hA0;
      step(s); chk("lock_b0_idx", out_src_idx, 2); chk("lock_b0_busy", busy, 1);
      in_data[2] = 64'hA1;
      step(s); chk("lock_b1_idx", out_src_idx, 2); chk("lock_b1_busy", busy, 1);
      in_eop[2] = 1'b1; in_data[2] = 64'hA2;
      step(s); chk("lock_b2_idx", out_src_idx, 2); chk("lock_b2_busy", busy, 0);
      in_valid = 4'b0001;
      step(s); chk("lock_next_idx", out_src_idx, 0); chk("lock_next_data", out_data, 64'h0A0A);

      // Backpressure mid-packet.
      do_reset();
      in_valid = 4'b1000; in_eop = '0; in_data[3] = 64'hB0; out_ready = 1'b1;
      step(s);
      in_valid = 4'b1001; in_data[3] = 64'hB1; out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         step(s);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold_data", out_data, 64'hB0);
      end
      out_ready = 1'b1;
      step(s); chk("bp_resume", out_data, 64'hB1);
      in_eop[3] = 1'b1; in_data[3] = 64'hB2;
      step(s); chk("bp_last", out_data, 64'hB2);
      in_valid = '0;
      step(s); chk("drain_valid", out_valid, 0);

      // Lock owner stalls while others request.
      do_reset();
      in_valid = 4'b0100; in_eop = '0; in_data[2] = 64'hC0;
      step(s);
      in_valid = 4'b1011; in_eop = 4'b1011;
      for (int j = 0; j < 4; j++) begin
         step(s);
         chk("stall_busy", busy, 1);
         chk("stall_ready", in_ready, 4'b0100);
      end
      chk("stall_drained", out_valid, 0);
      in_valid = '1; in_eop = '1; in_data[2] = 64'hC1;
      step(s); chk("stall_end_idx", out_src_idx, 2);
      step(s); chk("stall_after_idx", out_src_idx, 3);

      // Async reset between edges while a packet is locked.
      do_reset();
      in_valid = 4'b0001; in_eop = '0; in_data[0] = 64'hD0;
      step(s);
      chk("ar_busy_pre", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_in_ready", in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      in_valid = 4'b1010; in_eop = '1;
      step(s); chk("ar_first_grant", out_src_idx, 1);

      // Randomized multi-beat traffic with random sink backpressure.
      do_reset();
      for (int i = 0; i < N; i++) begin seq[i] = 0; rem[i] = 0; end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
            in_valid[i] = ($urandom_range(0, 3) != 0);
            in_eop[i]   = (rem[i] == 1);
            in_data[i]  = {8'(i), 24'(seq[i]), 32'($urandom)};
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step(s);
         if (s >= 0) begin rem[s]--; seq[s]++; end
      end

`ifdef OFS_PLAT_PRIM_ARB_PKT_MUX_STATS_EN
      // Counter saturation: 70000 single-beat packets from client 1.
      do_reset();
      in_valid = 4'b0010; in_eop = '1; out_ready = 1'b1;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      chk("stat_sat_1", stat_pkt_cnt[1], 16'hFFFF);
      chk("stat_sat_0", stat_pkt_cnt[0], 0);
      chk("stat_sat_2", stat_pkt_cnt[2], 0);
      chk("stat_sat_3", stat_pkt_cnt[3], 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
